// File: rtl/spi_host_ctrl_if.sv
// Command / TX / RX bus between the register-access logic and spi_host_ctrl.
// The controller takes the slave modport; the requester takes the master modport.
interface spi_host_ctrl_if #(
    parameter int LEN_W = 9
);
    // A cmd or tx transfer happens on the clk edge where valid && ready are both 1; the
    // requester holds valid and its payload stable until then. rx_valid is a one-cycle
    // strobe with no ready, so the receiver must always accept it.
    logic             cmd_valid;
    logic             cmd_ready;
    logic [7:0]       cmd_addr;
    logic [LEN_W-1:0] cmd_len;
    logic             cmd_sync;
    logic [7:0]       tx_data;
    logic             tx_valid;
    logic             tx_ready;
    logic [7:0]       rx_data;
    logic             rx_valid;
    logic [7:0]       rx_addr;
    logic             busy;

    modport master (
        output cmd_valid, cmd_addr, cmd_len, cmd_sync, tx_data, tx_valid,
        input  cmd_ready, tx_ready, rx_data, rx_valid, rx_addr, busy
    );

    modport slave (
        input  cmd_valid, cmd_addr, cmd_len, cmd_sync, tx_data, tx_valid,
        output cmd_ready, tx_ready, rx_data, rx_valid, rx_addr, busy
    );
endinterface

// File: rtl/spi_host_ctrl.sv
// Host-side serial initiator: optional iclk preamble, address byte, then full-duplex data bytes, LSB first.
// Define SPI_HOST_AUTO_SYNC_EN to force the iclk preamble on every command (cmd_sync ignored).
module spi_host_ctrl #(
    parameter int SCLK_HALF   = 1,
    parameter int ICLK_PULSES = 8,
    parameter int LEN_W       = 9
) (
    input  logic           clk,
    input  logic           rst,
    spi_host_ctrl_if.slave bus,
    output logic           sclk,
    output logic           iclk,
    output logic           serial_in,
    input  logic           serial_out,
    output logic [2:0]     dbg_state
);
    localparam int CW = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;
    localparam int PW = (ICLK_PULSES > 1) ? $clog2(ICLK_PULSES) : 1;

    typedef enum logic [2:0] {IDLE, SYNC_HI, SYNC_LO, ADDR, LOAD, DATA, DONE} state_t;

    state_t           state, state_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic             phase, phase_n;
    logic [2:0]       bit_idx, bit_n;
    logic [PW-1:0]    pulse, pulse_n;
    logic [7:0]       sh, sh_n;
    logic [7:0]       addr_q, addr_n;
    logic [7:0]       idx, idx_n;
    logic [7:0]       rx_shift, rx_shift_n;
    logic [LEN_W-1:0] rem, rem_n;
    logic             half_end, do_sync, rx_fire;
    logic             sclk_n, iclk_n, serial_in_n, cmd_ready_n, busy_n, tx_ready_n, rx_valid_n;
    logic [7:0]       rx_data_n, rx_addr_n;

    assign half_end  = (cnt == CW'(SCLK_HALF - 1));
    assign dbg_state = state;
`ifdef SPI_HOST_AUTO_SYNC_EN
    assign do_sync = bus.cmd_sync | 1'b1;
`else
    assign do_sync = bus.cmd_sync;
`endif

    // Outputs are registered from the next-state values so they line up with the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            phase         <= 1'b0;
            bit_idx       <= 3'd0;
            pulse         <= '0;
            sh            <= 8'h00;
            addr_q        <= 8'h00;
            idx           <= 8'h00;
            rx_shift      <= 8'h00;
            rem           <= '0;
            sclk          <= 1'b0;
            iclk          <= 1'b0;
            serial_in     <= 1'b0;
            bus.cmd_ready <= 1'b1;
            bus.busy      <= 1'b0;
            bus.tx_ready  <= 1'b0;
            bus.rx_valid  <= 1'b0;
            bus.rx_data   <= 8'h00;
            bus.rx_addr   <= 8'h00;
        end else begin
            state         <= state_n;
            cnt           <= cnt_n;
            phase         <= phase_n;
            bit_idx       <= bit_n;
            pulse         <= pulse_n;
            sh            <= sh_n;
            addr_q        <= addr_n;
            idx           <= idx_n;
            rx_shift      <= rx_shift_n;
            rem           <= rem_n;
            sclk          <= sclk_n;
            iclk          <= iclk_n;
            serial_in     <= serial_in_n;
            bus.cmd_ready <= cmd_ready_n;
            bus.busy      <= busy_n;
            bus.tx_ready  <= tx_ready_n;
            bus.rx_valid  <= rx_valid_n;
            bus.rx_data   <= rx_data_n;
            bus.rx_addr   <= rx_addr_n;
        end
    end

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        phase_n    = phase;
        bit_n      = bit_idx;
        pulse_n    = pulse;
        sh_n       = sh;
        addr_n     = addr_q;
        idx_n      = idx;
        rx_shift_n = rx_shift;
        rem_n      = rem;
        case (state)
            IDLE: begin
                if (bus.cmd_valid) begin
                    addr_n  = bus.cmd_addr;
                    sh_n    = bus.cmd_addr;
                    rem_n   = bus.cmd_len;
                    idx_n   = 8'h00;
                    cnt_n   = '0;
                    phase_n = 1'b0;
                    bit_n   = 3'd0;
                    pulse_n = '0;
                    state_n = do_sync ? SYNC_HI : ADDR;
                end
            end
            SYNC_HI: begin
                if (half_end) begin
                    cnt_n   = '0;
                    state_n = SYNC_LO;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            SYNC_LO: begin
                if (half_end) begin
                    cnt_n   = '0;
                    pulse_n = pulse + 1'b1;
                    state_n = (pulse == PW'(ICLK_PULSES - 1)) ? ADDR : SYNC_HI;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            ADDR, DATA: begin
                if (!half_end) begin
                    cnt_n = cnt + 1'b1;
                end else if (!phase) begin
                    cnt_n   = '0;
                    phase_n = 1'b1;
                end else begin
                    // Last cycle of the high phase: sample, then sclk falls into the next setup.
                    cnt_n               = '0;
                    phase_n             = 1'b0;
                    rx_shift_n[bit_idx] = serial_out;
                    bit_n               = bit_idx + 1'b1;
                    if (bit_idx == 3'd7) begin
                        if (state == ADDR) begin
                            state_n = (rem != '0) ? LOAD : DONE;
                        end else begin
                            rem_n   = rem - 1'b1;
                            idx_n   = idx + 1'b1;
                            state_n = (rem == LEN_W'(1)) ? DONE : LOAD;
                        end
                    end
                end
            end
            LOAD: begin
                if (bus.tx_valid) begin
                    sh_n    = bus.tx_data;
                    state_n = DATA;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        sclk_n      = 1'b0;
        serial_in_n = serial_in;
        iclk_n      = (state_n == SYNC_HI);
        if (state_n == ADDR || state_n == DATA) begin
            sclk_n      = phase_n;
            serial_in_n = sh_n[bit_n];
        end
        cmd_ready_n = (state_n == IDLE);
        busy_n      = (state_n != IDLE);
        tx_ready_n  = (state_n == LOAD);
        rx_fire     = (state == DATA) && phase && half_end && (bit_idx == 3'd7);
        rx_valid_n  = rx_fire;
        rx_data_n   = rx_fire ? rx_shift_n : bus.rx_data;
        rx_addr_n   = rx_fire ? (addr_q + idx) : bus.rx_addr;
    end
endmodule

// File: tb/tb_spi_host_ctrl.sv
// Bench for spi_host_ctrl: pin-level chip model, transaction-level reference memory,
// rx scoreboard queue and wire-byte queue, randomized commands.
module tb_spi_host_ctrl;
  localparam int LEN_W       = 9;
  localparam int ICLK_PULSES = 8;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sclk, iclk, serial_in;
  logic       serial_out = 1'b0;
  logic [2:0] dbg_state;

  always #5 clk = ~clk;

  spi_host_ctrl_if #(.LEN_W(LEN_W)) bus();

  spi_host_ctrl #(
    .SCLK_HALF(1),
    .ICLK_PULSES(ICLK_PULSES),
    .LEN_W(LEN_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .sclk(sclk),
    .iclk(iclk),
    .serial_in(serial_in),
    .serial_out(serial_out),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int          checks = 0;
  int          failures = 0;
  logic [15:0] exp_q[$];       // {rx_addr, rx_data}
  logic [7:0]  exp_wire_q[$];  // bytes expected on serial_in
  logic [7:0]  ref_mem[256];
  logic [7:0]  cur_tx[$];
  int          sclk_rises = 0;
  int          iclk_rises = 0;
  int          overlap_cnt = 0;
  int          stray_sclk = 0;
  int          stall_sclk = 0;
  int          frame_gen = 0;
  int          tx_ptr = 0;
  int          tx_stall = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] init_val(input int i);
    logic [55:0] ch0;
    ch0 = 56'h2D2D2D2D2D2D3;
    if (i >= 4 && i <= 10) return ch0[8*(i-4) +: 8];
    return 8'(i * 37 + 11);
  endfunction

  // ---------------- chip model ----------------
  logic [7:0] chip_mem[256];
  bit         chip_inited = 1'b0;
  int         chip_seen_gen = 0;
  logic [2:0] chip_bits = 3'd0;
  int         chip_byte_no = 0;
  logic [7:0] chip_in = 8'h00;
  logic [7:0] chip_ptr = 8'h00;
  logic [7:0] chip_out = 8'h00;

  always @(posedge sclk) begin
    if (!chip_inited) begin
      for (int i = 0; i < 256; i++) chip_mem[i] = init_val(i);
      chip_inited = 1'b1;
    end
    if (chip_seen_gen != frame_gen) begin
      chip_seen_gen = frame_gen;
      chip_bits     = 3'd0;
      chip_byte_no  = 0;
    end
    chip_in[chip_bits] = serial_in;
    if (chip_bits == 3'd7) begin
      check("wire_byte_expected", 32'(exp_wire_q.size() != 0), 32'd1);
      if (exp_wire_q.size() != 0) check("wire_byte", 32'(chip_in), 32'(exp_wire_q.pop_front()));
      if (chip_byte_no == 0) begin
        chip_ptr = chip_in;
      end else begin
        chip_mem[chip_ptr] = chip_in;
        chip_ptr = chip_ptr + 8'd1;
      end
      chip_out = chip_mem[chip_ptr];
      chip_byte_no++;
    end
    chip_bits = chip_bits + 3'd1;
    sclk_rises++;
  end

  always @(negedge sclk) serial_out = chip_out[chip_bits];

  always @(posedge iclk) iclk_rises++;

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [15:0] e;
    if (sclk && iclk) overlap_cnt++;
    if (sclk && !bus.busy) stray_sclk++;
    if (bus.rx_valid) begin
      check("rx_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("rx_addr", 32'(bus.rx_addr), 32'(e[15:8]));
        check("rx_data", 32'(bus.rx_data), 32'(e[7:0]));
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic tx_step(input int stall_byte, input int stall_cyc);
    if (bus.tx_valid) begin
      tx_ptr++;
      bus.tx_valid = 1'b0;
    end
    if (bus.tx_ready && tx_ptr < cur_tx.size()) begin
      if (tx_ptr == stall_byte && tx_stall < stall_cyc) begin
        tx_stall++;
        if (sclk) stall_sclk++;
      end else begin
        bus.tx_valid = 1'b1;
        bus.tx_data  = cur_tx[tx_ptr];
      end
    end
  endtask

  task automatic issue_cmd(input logic [7:0] addr, input int len, input bit sync);
    int w;
    w = 0;
    while (!bus.cmd_ready && w < 1000) begin
      @(negedge clk);
      w++;
    end
    bus.cmd_valid = 1'b1;
    bus.cmd_addr  = addr;
    bus.cmd_len   = LEN_W'(len);
    bus.cmd_sync  = sync;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    tx_ptr   = 0;
    tx_stall = 0;
  endtask

  task automatic run_cmd(input logic [7:0] addr, input int len, input bit sync,
                         input int stall_byte, input int stall_cyc);
    int         n, s0, i0, exp_cyc;
    bit         sync_eff;
    logic [7:0] a;
`ifdef SPI_HOST_AUTO_SYNC_EN
    sync_eff = 1'b1;
`else
    sync_eff = sync;
`endif
    exp_wire_q.push_back(addr);
    for (int i = 0; i < len; i++) begin
      a = addr + 8'(i);
      exp_q.push_back({a, ref_mem[a]});
      ref_mem[a] = cur_tx[i];
      exp_wire_q.push_back(cur_tx[i]);
    end
    frame_gen++;
    s0 = sclk_rises;
    i0 = iclk_rises;
    stall_sclk = 0;
    issue_cmd(addr, len, sync);
    n = 1;
    while (!bus.cmd_ready && n < 5000) begin
      tx_step(stall_byte, stall_cyc);
      @(negedge clk);
      n++;
    end
    bus.tx_valid = 1'b0;
    exp_cyc = (sync_eff ? 16 * ICLK_PULSES / 8 : 0) + 16 + 17 * len + 2 +
              ((stall_byte >= 0 && stall_byte < len) ? stall_cyc : 0);
    check("done_latency", 32'(n), 32'(exp_cyc));
    check("sclk_rises", 32'(sclk_rises - s0), 32'(8 + 8 * len));
    check("iclk_pulses", 32'(iclk_rises - i0), sync_eff ? 32'(ICLK_PULSES) : 32'd0);
    check("rx_left", 32'(exp_q.size()), 32'd0);
    check("wire_left", 32'(exp_wire_q.size()), 32'd0);
    check("busy_after", 32'(bus.busy), 32'd0);
    if (stall_cyc > 0 && stall_byte >= 0 && stall_byte < len)
      check("stall_sclk", 32'(stall_sclk), 32'd0);
    exp_q.delete();
    exp_wire_q.delete();
  endtask

  task automatic run_reset_test();
    int         n, s0;
    logic [7:0] addr;
    cur_tx.delete();
    cur_tx.push_back(8'($urandom_range(0, 255)));
    cur_tx.push_back(8'($urandom_range(0, 255)));
    addr = 8'($urandom_range(0, 255));
    exp_wire_q.push_back(addr);
    frame_gen++;
    s0 = sclk_rises;
    issue_cmd(addr, 2, 1'b0);
    n = 1;
    // 8 address rises + bits 0..2 of the first data byte, then the rise of bit 3
    while ((sclk_rises - s0) < 12 && n < 2000) begin
      tx_step(-1, 0);
      @(negedge clk);
      n++;
    end
    check("rst_reach_bit3", 32'(sclk_rises - s0), 32'd12);
    rst = 1'b1;
    bus.tx_valid = 1'b0;
    @(negedge clk);
    check("rst_mid_sclk", 32'(sclk), 32'd0);
    check("rst_mid_iclk", 32'(iclk), 32'd0);
    check("rst_mid_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check("rst_mid_rx_valid", 32'(bus.rx_valid), 32'd0);
    check("rst_mid_busy", 32'(bus.busy), 32'd0);
    check("rst_mid_tx_ready", 32'(bus.tx_ready), 32'd0);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("rst_wire_left", 32'(exp_wire_q.size()), 32'd0);
    exp_wire_q.delete();
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    int         s0, i0, len, sb, sc;
    logic [7:0] addr;
    bit         sync;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
    bus.cmd_valid = 1'b0;
    bus.cmd_addr  = 8'h00;
    bus.cmd_len   = '0;
    bus.cmd_sync  = 1'b0;
    bus.tx_data   = 8'h00;
    bus.tx_valid  = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_sclk", 32'(sclk), 32'd0);
    check("rst_iclk", 32'(iclk), 32'd0);
    check("rst_serial_in", 32'(serial_in), 32'd0);
    check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_tx_ready", 32'(bus.tx_ready), 32'd0);
    check("rst_rx_valid", 32'(bus.rx_valid), 32'd0);
    check("rst_rx_data", 32'(bus.rx_data), 32'd0);
    check("rst_rx_addr", 32'(bus.rx_addr), 32'd0);
    rst = 1'b0;
    s0 = sclk_rises;
    i0 = iclk_rises;
    repeat (50) @(negedge clk);
    check("idle_sclk_edges", 32'(sclk_rises - s0), 32'd0);
    check("idle_iclk_edges", 32'(iclk_rises - i0), 32'd0);
    check("idle_cmd_ready", 32'(bus.cmd_ready), 32'd1);

    // Write 0x10,0x20,0x30 at 1..3, then the same command reads them back.
    for (int k = 0; k < 2; k++) begin
      cur_tx.delete();
      cur_tx.push_back(8'h10);
      cur_tx.push_back(8'h20);
      cur_tx.push_back(8'h30);
      run_cmd(8'h01, 3, 1'b1, -1, 0);
    end

    // Chip preloaded with the ch0 word at addresses 4..10.
    cur_tx.delete();
    for (int i = 0; i < 7; i++) cur_tx.push_back(8'h00);
    run_cmd(8'h04, 7, 1'b1, -1, 0);

    // 40-cycle tx stall before the second byte.
    cur_tx.delete();
    cur_tx.push_back(8'($urandom_range(0, 255)));
    cur_tx.push_back(8'($urandom_range(0, 255)));
    run_cmd(8'($urandom_range(0, 255)), 2, 1'b0, 1, 40);

    // Address byte only.
    cur_tx.delete();
    run_cmd(8'($urandom_range(0, 255)), 0, 1'b1, -1, 0);

    run_reset_test();

    // Address wrap 0xFD..0x01.
    cur_tx.delete();
    for (int i = 0; i < 5; i++) cur_tx.push_back(8'($urandom_range(0, 255)));
    run_cmd(8'hFD, 5, 1'b1, -1, 0);

    for (int k = 0; k < 6; k++) begin
      len  = int'($urandom_range(0, 5));
      addr = 8'($urandom_range(0, 255));
      sync = 1'($urandom_range(0, 1));
      sb   = int'($urandom_range(0, 5));
      sc   = int'($urandom_range(0, 10));
      cur_tx.delete();
      for (int j = 0; j < len; j++) cur_tx.push_back(8'($urandom_range(0, 255)));
      run_cmd(addr, len, sync, sb, sc);
    end

    check("sclk_iclk_overlap", 32'(overlap_cnt), 32'd0);
    check("sclk_outside_busy", 32'(stray_sclk), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/spi_host_ctrl.md
Name: spi_host_ctrl

Overview:
- Host-side initiator for the chip's serial configuration/readout port.
- Generates `sclk`, `iclk` and the chip's `serial_in` line, and captures the chip's `serial_out` line.
- Converts a command (start address + byte count) plus a TX byte stream into the on-wire sequence: iclk sync preamble, address byte, then N full-duplex data bytes, all LSB first.
- Each received byte is returned on an RX strobe.
- Sits in the FPGA/test-harness side, between the register-access logic and the chip pins.

Parameters:
- SCLK_HALF, 1, clk cycles per sclk/iclk half-period (>=1).
- ICLK_PULSES, 8, iclk pulses in the sync preamble; the chip's address pointer clears after 8.
- LEN_W, 9, width of cmd_len.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  controller idle, accepts command
- cmd_addr  in  8  start register address (first byte on wire)
- cmd_len  in  LEN_W  data bytes after the address byte (0 allowed)
- cmd_sync  in  1  request iclk preamble before the address byte
- tx_data  in  8  next data byte to shift out
- tx_valid  in  1  tx_data valid
- tx_ready  out  1  tx byte consumed when tx_valid && tx_ready
- rx_data  out  8  received data byte
- rx_valid  out  1  one-cycle strobe per received data byte; no backpressure
- rx_addr  out  8  register address of rx_data (cmd_addr + index, mod 256)
- busy  out  1  command in progress
- sclk  out  1  serial clock to chip
- iclk  out  1  internal-reset clock to chip
- serial_in  out  1  data to chip
- serial_out  in  1  data from chip

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst). All outputs are registered.
- Reset values: sclk=0, iclk=0, serial_in=0, cmd_ready=1, busy=0, tx_ready=0, rx_valid=0, rx_data=0, rx_addr=0.
- rst overrides every state, including mid-command. No partial rx_valid is emitted. The next cycle is IDLE.
- FSM states: IDLE, SYNC_HI, SYNC_LO, ADDR, LOAD, DATA, DONE.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid: latch addr, len and sync; cmd_ready=0; busy=1.
  - If sync, go to SYNC_HI, else ADDR.
- SYNC_HI / SYNC_LO:
  - iclk high for SCLK_HALF cycles, then low for SCLK_HALF cycles.
  - Repeat ICLK_PULSES times, then go to ADDR.
  - sclk held 0 throughout.
  - iclk and sclk are never high simultaneously.
- Bit cell (used by ADDR and DATA), bit j=0..7, LSB first:
  - Setup phase: serial_in=byte[j], sclk=0 for SCLK_HALF cycles.
  - High phase: sclk=1 for SCLK_HALF cycles.
  - serial_out is sampled into rx_shift[j] in the last cycle of the high phase.
  - sclk falls on the next cycle, which starts the next bit's setup.
- ADDR:
  - Shifts the latched address.
  - Sampled bits are discarded.
  - Then go to LOAD if len>0, else DONE.
- LOAD:
  - tx_ready=1.
  - Stays in LOAD with sclk=0 and serial_in unchanged until tx_valid. Stalls of any length are legal.
  - On the handshake: capture the byte, go to DATA.
- DATA:
  - Shifts the captured byte.
  - After bit 7 is sampled, the next cycle drives rx_valid=1, rx_data=rx_shift, rx_addr=addr+index.
  - Decrement the remaining count. If nonzero go to LOAD, else DONE.
- DONE:
  - One cycle, sclk=0.
  - Then IDLE with cmd_ready=1 and busy=0.
- Timing at SCLK_HALF=1, no stall, sync=1:
  - Preamble 16 cycles.
  - Address 16 cycles.
  - Each data byte 1 + 16 cycles.
  - cmd_ready returns 1 exactly 16·ICLK_PULSES/8 + 16 + 17·len + 2 cycles after acceptance.
- Address wrap: rx_addr wraps 255→0. The controller does not check address validity.
- Each bit transmits exactly one sclk rising edge. No sclk edges outside bit cells.

Optional Feature:
- Macro: SPI_HOST_AUTO_SYNC_EN.
- Defined: every command executes the iclk preamble; cmd_sync is ignored.
- Undefined: the preamble runs only when cmd_sync=1 at acceptance.

Test Plan:
- Reset → all outputs at listed reset values; sclk/iclk have no edges for 50 cycles.
- cmd addr=0x01, len=3, sync=1, tx 0x10,0x20,0x30, chip model attached:
  - exactly 8 iclk pulses;
  - serial_in shows 0x01 LSB-first;
  - 32 sclk rises in total;
  - 3 rx_valid with rx_addr 1,2,3.
- Second identical command → rx_data sequence 0x10,0x20,0x30 (write read-back).
- addr=0x04, len=7, tx all 0x00, ch0=50'h2D2D2D2D2D2D3 → rx_data D3,D2,D2,D2,D2,D2,02; rx_addr 4..10.
- len=2 with tx_valid withheld 40 cycles before byte 2 → sclk stays 0 during the stall; rx data unchanged versus the no-stall case.
- rst pulsed during DATA bit 3 of byte 1 → next cycle sclk=0, iclk=0, cmd_ready=1, and no rx_valid.
- len=0 → only the address byte is shifted (8 sclk rises); no rx_valid; cmd_ready returns 1.
